// File: rtl/wb_dma_pkg.sv
// wb_dma_pkg: shared definitions for the wb_dma copy engine.
//   - Config register offsets (slave address bits [3:2]).
//   - Bit positions inside the CTRL register.
//   - Master-side FSM state encoding.
package wb_dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;  // write 1 to launch, always reads 0
    localparam int CTRL_BUSY  = 1;  // read-only
    localparam int CTRL_DONE  = 2;  // write 1 to clear
    localparam int CTRL_IE    = 3;  // interrupt enable
    localparam int CTRL_ERR   = 4;  // write 1 to clear

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_dma_buf.sv
// wb_dma_buf: BURST-deep word buffer holding one read chunk until it is
// written back out.
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          rewind both pointers at the start of a chunk
//   push_i/push_data_i   store one word at the write pointer
//   pop_i          advance the read pointer
//   head_o         word at the read pointer
//   next_o         word after the read pointer, so the master can present
//                  the following write word on the cycle after an ack
module wb_dma_buf
    import wb_dma_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] head_o,
    output logic [31:0] next_o
);

    localparam int PTR_W = (BURST > 1) ? $clog2(BURST) : 1;

    logic [31:0]      mem_q [BURST];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BURST - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; a word is only ever read after it
    // was pushed in the same chunk, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign next_o = mem_q[ptr_inc(rd_ptr_q)];

endmodule

// File: rtl/wb_dma.sv
// wb_dma: single-channel Wishbone memory-to-memory copy engine.
//   clk_i, rst_i            bus clock, synchronous active-high reset
//   s_*                     config slave: SRC, DST, LEN, CTRL at adr[3:2]
//   m_*                     bus master: reads a chunk of up to BURST words
//                           into wb_dma_buf, then writes it back out
//   irq_o                   level interrupt, done & ie
module wb_dma
    import wb_dma_pkg::*;
#(
    parameter int BURST = 4,
    parameter int LEN_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_sel_i,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    output logic        s_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        irq_o
);

    localparam int CNT_W = $clog2(BURST + 1);

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ie_q, ie_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;      // words left in the current chunk
    logic [CNT_W-1:0]   chunk_q, chunk_d;  // size of the current chunk
    logic               s_ack_q, s_ack_d;
    logic               s_seen_q, s_seen_d;
    logic [31:0]        s_dat_q, s_dat_d;
    logic               m_cyc_q, m_cyc_d;
    logic               m_stb_q, m_stb_d;
    logic               m_we_q, m_we_d;
    logic [31:0]        m_adr_q, m_adr_d;
    logic [31:0]        m_dat_q, m_dat_d;

    logic               s_req, busy, start;
    logic [CNT_W-1:0]   chunk;
    logic               buf_clr, buf_push, buf_pop;
    logic [31:0]        buf_head, buf_next;

    // Byte selects and the undecoded address bits have no effect.
    logic unused_ok;
    assign unused_ok = ^{s_sel_i, s_adr_i[31:4], s_adr_i[1:0]};

    wb_dma_buf #(.BURST(BURST)) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (buf_clr),
        .push_i      (buf_push),
        .push_data_i (m_dat_i),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .next_o      (buf_next)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        ie_d     = ie_q;
        done_d   = done_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        chunk_d  = chunk_q;
        m_cyc_d  = m_cyc_q;
        m_stb_d  = m_stb_q;
        m_we_d   = m_we_q;
        m_adr_d  = m_adr_q;
        m_dat_d  = m_dat_q;
        s_dat_d  = '0;
        start    = 1'b0;
        buf_clr  = 1'b0;
        buf_push = 1'b0;
        buf_pop  = 1'b0;
        chunk    = (len_q < LEN_W'(BURST)) ? CNT_W'(len_q) : CNT_W'(BURST);
        busy     = (state_q != ST_IDLE);

        // Config slave: ack once per strobe; s_seen holds off a second ack
        // until the master drops the request.
        s_req    = s_cyc_i & s_stb_i;
        s_seen_d = s_req;
        s_ack_d  = s_req & ~s_seen_q;

        if (s_ack_d) begin
            if (s_we_i) begin
                case (s_adr_i[3:2])
                    REG_SRC: if (!busy) src_d = {s_dat_i[31:2], 2'b00};
                    REG_DST: if (!busy) dst_d = {s_dat_i[31:2], 2'b00};
                    REG_LEN: if (!busy) len_d = s_dat_i[LEN_W-1:0];
                    default: begin
                        ie_d  = s_dat_i[CTRL_IE];
                        start = s_dat_i[CTRL_START] & ~busy;
                        if (s_dat_i[CTRL_DONE]) done_d = 1'b0;
                        if (s_dat_i[CTRL_ERR])  err_d  = 1'b0;
                    end
                endcase
            end else begin
                case (s_adr_i[3:2])
                    REG_SRC: s_dat_d = src_q;
                    REG_DST: s_dat_d = dst_q;
                    REG_LEN: s_dat_d = 32'(len_q);
                    default: begin
                        s_dat_d[CTRL_BUSY] = busy;
                        s_dat_d[CTRL_DONE] = done_q;
                        s_dat_d[CTRL_IE]   = ie_q;
                        s_dat_d[CTRL_ERR]  = err_q;
                    end
                endcase
            end
        end

        // The FSM is evaluated after the CPU writes, so a done/err set here
        // overrides a write-1-to-clear landing in the same cycle.
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = (len_q == '0) ? ST_FIN : ST_RD;
            end
            ST_RD: begin
                if (!m_cyc_q) begin
                    // Idle cycle between phases: open a new read chunk.
                    buf_clr = 1'b1;
                    cnt_d   = chunk;
                    chunk_d = chunk;
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    m_we_d  = 1'b0;
                    m_adr_d = src_q;
                    m_dat_d = '0;
                end else if (m_err_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (m_ack_i) begin
                    buf_push = 1'b1;
                    src_d    = src_q + 32'd4;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                        state_d = ST_WR;
                    end else begin
                        m_adr_d = src_q + 32'd4;
                    end
                end
            end
            ST_WR: begin
                if (!m_cyc_q) begin
                    cnt_d   = chunk_q;
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    m_we_d  = 1'b1;
                    m_adr_d = dst_q;
                    m_dat_d = buf_head;
                end else if (m_err_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (m_ack_i) begin
                    buf_pop = 1'b1;
                    dst_d   = dst_q + 32'd4;
                    len_d   = len_q - 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                        m_we_d  = 1'b0;
                        state_d = (len_q == LEN_W'(1)) ? ST_FIN : ST_RD;
                    end else begin
                        m_adr_d = dst_q + 32'd4;
                        m_dat_d = buf_next;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            ie_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            chunk_q  <= '0;
            s_ack_q  <= 1'b0;
            s_seen_q <= 1'b0;
            s_dat_q  <= '0;
            m_cyc_q  <= 1'b0;
            m_stb_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            chunk_q  <= chunk_d;
            s_ack_q  <= s_ack_d;
            s_seen_q <= s_seen_d;
            s_dat_q  <= s_dat_d;
            m_cyc_q  <= m_cyc_d;
            m_stb_q  <= m_stb_d;
            m_we_q   <= m_we_d;
            m_adr_q  <= m_adr_d;
            m_dat_q  <= m_dat_d;
        end
    end

    assign s_ack_o = s_ack_q;
    assign s_dat_o = s_dat_q;
    assign m_cyc_o = m_cyc_q;
    assign m_stb_o = m_stb_q;
    assign m_we_o  = m_we_q;
    assign m_sel_o = 4'hF;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign irq_o   = done_q & ie_q;

endmodule

// File: tb/tb_wb_dma.sv
// tb_wb_dma: self-checking bench for wb_dma. A Wishbone slave model answers
// the master port and pops an expected-transaction queue on every
// termination; the config port is driven by a small register-access task.
module tb_wb_dma;
    import wb_dma_pkg::*;

    localparam int BURST = 4;
    localparam int LEN_W = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [3:0]  s_sel_i;
    logic [31:0] s_adr_i, s_dat_i, s_dat_o;
    logic        s_ack_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic        m_ack_i, m_err_i;
    logic        irq_o;

    wb_dma #(.BURST(BURST), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    xact_t       exp_q[$];
    logic [31:0] dmem [logic [31:0]];
    int          checks   = 0;
    int          failures = 0;
    int          max_wait = 0;
    int          err_on_read = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          cyc_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk_i) if (m_cyc_o) cyc_count <= cyc_count + 1;

    // Slave model on the master port: optional random wait states, optional
    // error on the Nth read, and a scoreboard pop on every termination.
    initial begin : slave_model
        bit          pending;
        bit          err_seen;
        int          wait_left;
        logic [31:0] p_adr, p_dat;
        logic        p_we;
        xact_t       e;
        pending = 0; err_seen = 0; wait_left = 0;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
        forever begin
            @(negedge clk_i);
            m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
            if (err_seen) begin
                err_seen = 0;
                check("cyc_low_after_err", 32'(m_cyc_o), 32'd0);
            end
            if (rst_i || !(m_cyc_o && m_stb_o)) begin
                pending = 0;
                continue;
            end
            if (!pending) begin
                pending   = 1;
                wait_left = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
                p_adr = m_adr_o; p_dat = m_dat_o; p_we = m_we_o;
            end else begin
                check("hold_adr", m_adr_o, p_adr);
                check("hold_we", 32'(m_we_o), 32'(p_we));
                if (p_we) check("hold_dat", m_dat_o, p_dat);
            end
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                pending = 0;
                check("m_sel", 32'(m_sel_o), 32'hF);
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bus_we", 32'(m_we_o), 32'(e.we));
                    check("bus_adr", m_adr_o, e.adr);
                    if (m_we_o) check("bus_dat", m_dat_o, e.dat);
                end
                if (!m_we_o) begin
                    rd_count++;
                    if (rd_count == err_on_read) begin
                        m_err_i  = 1'b1;
                        err_seen = 1;
                    end else begin
                        m_ack_i = 1'b1;
                        m_dat_i = pattern(m_adr_o);
                    end
                end else begin
                    wr_count++;
                    dmem[m_adr_o] = m_dat_o;
                    m_ack_i = 1'b1;
                end
            end
        end
    end

    // One config access; the ack must arrive exactly one cycle after stb.
    task automatic cfg(input logic we, input logic [1:0] r, input logic [31:0] wdat,
                       output logic [31:0] rdat);
        @(negedge clk_i);
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
        s_adr_i = {28'h0, r, 2'b00}; s_dat_i = wdat;
        @(negedge clk_i);
        check("s_ack", 32'(s_ack_o), 32'd1);
        rdat = s_dat_o;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        cfg(1'b1, r, d, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] r, input logic [31:0] exp);
        logic [31:0] got;
        cfg(1'b0, r, 32'h0, got);
        check(tag, got, exp);
    endtask

    // Expected bus traffic of a complete copy: chunks of BURST reads then writes.
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        int n;
        while (len > 0) begin
            n = (len < BURST) ? len : BURST;
            for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, src + 32'(4 * i), 32'h0});
            for (int i = 0; i < n; i++)
                exp_q.push_back('{1'b1, dst + 32'(4 * i), pattern(src + 32'(4 * i))});
            src += 32'(4 * n);
            dst += 32'(4 * n);
            len -= n;
        end
    endtask

    task automatic check_mem(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = dst + 32'(4 * i);
            check("dst_data", dmem.exists(a) ? dmem[a] : 32'hDEAD_BEEF, pattern(src + 32'(4 * i)));
        end
    endtask

    task automatic wait_idle();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 600; i++) begin
            cfg(1'b0, REG_CTRL, 32'h0, c);
            if (!c[CTRL_BUSY]) break;
        end
        check("busy_clear", 32'(c[CTRL_BUSY]), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_cyc"}, 32'(m_cyc_o), 32'd0);
        check({tag, "_m_stb"}, 32'(m_stb_o), 32'd0);
        check({tag, "_m_we"},  32'(m_we_o),  32'd0);
        check({tag, "_m_adr"}, m_adr_o, 32'd0);
        check({tag, "_m_dat"}, m_dat_o, 32'd0);
        check({tag, "_s_ack"}, 32'(s_ack_o), 32'd0);
        check({tag, "_s_dat"}, s_dat_o, 32'd0);
        check({tag, "_irq"},   32'(irq_o), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int          cyc_before;
        bit          found;
        rst_i = 1'b1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_sel_i = 4'hF; s_adr_i = '0; s_dat_i = '0;
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_i = 1'b0;

        // Register access.
        wr(REG_SRC, 32'h1000_0013);
        rd_check("src_readback", REG_SRC, 32'h1000_0010);
        wr(REG_LEN, 32'd6);
        rd_check("len_readback", REG_LEN, 32'd6);
        rd_check("ctrl_idle", REG_CTRL, 32'h0);

        // Six-word copy: chunks of 4 and 2, interrupt enabled.
        wr(REG_SRC, 32'h0000_0100);
        wr(REG_DST, 32'h1000_0200);
        wr(REG_LEN, 32'd6);
        rd_count = 0; wr_count = 0;
        push_copy(32'h0000_0100, 32'h1000_0200, 6);
        wr(REG_CTRL, 32'h9);
        wait_idle();
        check("copy_sb_empty", 32'(exp_q.size()), 32'd0);
        check("copy_reads", 32'(rd_count), 32'd6);
        check("copy_writes", 32'(wr_count), 32'd6);
        check_mem(32'h0000_0100, 32'h1000_0200, 6);
        rd_check("copy_ctrl", REG_CTRL, 32'h0C);
        check("copy_irq", 32'(irq_o), 32'd1);
        rd_check("copy_len", REG_LEN, 32'd0);
        wr(REG_CTRL, 32'h4);
        @(negedge clk_i);
        check("irq_cleared", 32'(irq_o), 32'd0);

        // Zero length: done without any bus cycle.
        wr(REG_LEN, 32'd0);
        cyc_before = cyc_count;
        wr(REG_CTRL, 32'h9);
        repeat (2) @(negedge clk_i);
        check("zero_irq", 32'(irq_o), 32'd1);
        check("zero_no_cyc", 32'(cyc_count - cyc_before), 32'd0);
        rd_check("zero_ctrl", REG_CTRL, 32'h0C);
        wr(REG_CTRL, 32'h4);

        // Error on the third read of an eight-word copy.
        dmem.delete();
        wr(REG_SRC, 32'h0000_2000);
        wr(REG_DST, 32'h0000_3000);
        wr(REG_LEN, 32'd8);
        rd_count = 0; wr_count = 0; err_on_read = 3;
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 32'h2000 + 32'(4 * i), 32'h0});
        wr(REG_CTRL, 32'h1);
        wait_idle();
        rd_check("err_ctrl", REG_CTRL, 32'h14);
        rd_check("err_len", REG_LEN, 32'd8);
        check("err_no_writes", 32'(wr_count), 32'd0);
        check("err_sb_empty", 32'(exp_q.size()), 32'd0);
        err_on_read = 0;
        wr(REG_CTRL, 32'h14);
        rd_check("err_cleared", REG_CTRL, 32'h0);

        // Random wait states, 37 words, source wrapping past 2^32.
        dmem.delete();
        max_wait = 3;
        wr(REG_SRC, 32'hFFFF_FFC0);
        wr(REG_DST, 32'h0000_8000);
        wr(REG_LEN, 32'd37);
        push_copy(32'hFFFF_FFC0, 32'h0000_8000, 37);
        wr(REG_CTRL, 32'h1);
        wait_idle();
        check("wait_sb_empty", 32'(exp_q.size()), 32'd0);
        check_mem(32'hFFFF_FFC0, 32'h0000_8000, 37);
        rd_check("wait_ctrl", REG_CTRL, 32'h04);
        wr(REG_CTRL, 32'h4);
        max_wait = 0;

        // Reset in the middle of a write phase, then a fresh copy.
        wr(REG_SRC, 32'h0000_0500);
        wr(REG_DST, 32'h0000_0600);
        wr(REG_LEN, 32'd6);
        push_copy(32'h0000_0500, 32'h0000_0600, 6);
        wr(REG_CTRL, 32'h9);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (m_cyc_o && m_we_o) begin
                found = 1;
                break;
            end
        end
        check("saw_write_phase", 32'(found), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_outputs_zero("midrst");
        rst_i = 1'b0;
        exp_q.delete();
        rd_check("midrst_ctrl", REG_CTRL, 32'h0);
        rd_check("midrst_len", REG_LEN, 32'h0);

        dmem.delete();
        wr(REG_SRC, 32'h0000_0700);
        wr(REG_DST, 32'h0000_0900);
        wr(REG_LEN, 32'd5);
        push_copy(32'h0000_0700, 32'h0000_0900, 5);
        wr(REG_CTRL, 32'h9);
        wait_idle();
        check("fresh_sb_empty", 32'(exp_q.size()), 32'd0);
        check_mem(32'h0000_0700, 32'h0000_0900, 5);
        rd_check("fresh_ctrl", REG_CTRL, 32'h0C);
        check("fresh_irq", 32'(irq_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dma.md
Name: wb_dma

Overview:
- Single-channel Wishbone memory-to-memory copy engine for the Plasma SOPC.
- Its master port drives wb_conmax master 2, a port left free for this block.
- Its slave config port hangs off a spare conmax slave port.
- It copies word blocks between on-chip RAM, SDRAM and peripherals without CPU load, and raises an interrupt when the copy finishes.

Parameters:
- BURST, 4, words buffered per read/write chunk; power of two, 1..16.
- LEN_W, 16, width of the word-count register.

Ports:
- clk_i  in  1  bus clock (clk_bus domain)
- rst_i  in  1  reset
- s_cyc_i  in  1  config slave cycle
- s_stb_i  in  1  config slave strobe
- s_we_i  in  1  config slave write enable
- s_sel_i  in  4  config slave byte selects (ignored; full-word access only)
- s_adr_i  in  32  config slave address; bits [3:2] decoded
- s_dat_i  in  32  config write data
- s_dat_o  out  32  config read data
- s_ack_o  out  1  config acknowledge
- m_cyc_o  out  1  master cycle
- m_stb_o  out  1  master strobe
- m_we_o  out  1  master write enable
- m_sel_o  out  4  master byte selects, constant 4'hF
- m_adr_o  out  32  master address, word aligned
- m_dat_o  out  32  master write data
- m_dat_i  in  32  master read data
- m_ack_i  in  1  master acknowledge
- m_err_i  in  1  master error
- irq_o  out  1  level interrupt, equal to done & ie

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: every output, register and the FSM go to 0 (FSM = IDLE).
- Config slave timing: s_ack_o asserts one cycle after s_cyc_i & s_stb_i, pulses for one cycle, and is not reasserted until stb has dropped.
- Register map (adr[3:2]):
  - 0 SRC: source address; bits [1:0] read 0.
  - 1 DST: destination address; bits [1:0] read 0.
  - 2 LEN: words to copy; reads the remaining count while busy.
  - 3 CTRL: bit0 start (write 1, reads 0); bit1 busy (read-only); bit2 done (write 1 to clear); bit3 ie; bit4 err (write 1 to clear).
- Register writes while busy: writes to SRC, DST and LEN are ignored. Start is also ignored while busy.
- FSM states: IDLE, RD, WR, FIN.
- IDLE + start:
  - LEN==0: go to FIN, no bus traffic.
  - Otherwise: chunk = min(BURST, LEN), go to RD.
- RD state:
  - m_cyc_o, m_stb_o = 1; m_we_o = 0; m_adr_o = src.
  - Each m_ack_i: capture m_dat_i into the buffer, src += 4, decrement chunk count.
  - stb stays high across consecutive words; the next address is presented the cycle after the ack.
  - Last ack of the chunk: drop cyc/stb for one cycle, go to WR.
- WR state:
  - m_we_o = 1; m_dat_o = buffer head.
  - Each ack: dst += 4, LEN -= 1.
  - Last ack of the chunk: drop cyc for one cycle; go to RD if LEN != 0, else FIN.
- FIN state: set done, clear busy, return to IDLE.
- Throughput: at most one word per ack. Wait states from the slave are tolerated indefinitely; stb, address and data stay stable until ack.
- m_err_i in RD or WR:
  - Terminate the cycle (cyc/stb low next cycle).
  - Set err and done; go to IDLE without FIN.
  - LEN holds the remaining count; nothing further is written.
- Simultaneous events:
  - If the DMA sets done and a CPU write-1-to-clear of done land in the same cycle, set wins. Same rule for err.
  - If ack and err arrive together, err wins.
- Address arithmetic wraps modulo 2^32. No boundary checks.
- LEN is LEN_W wide; writes are truncated to LEN_W bits.
- Reset mid-operation: cyc/stb go low at the reset edge, state is lost, irq_o = 0. Leaving the target slave mid-cycle is acceptable.

Decomposition:
- Package wb_dma_pkg holds:
  - register offsets REG_SRC, REG_DST, REG_LEN, REG_CTRL;
  - CTRL bit positions;
  - the FSM state enum.
- Sub-module wb_dma_buf: BURST-deep word buffer with write and read pointers, clear on chunk start. The top holds the FSM, the registers and both bus ports.

Test Plan:
- Register access: write SRC=0x1000_0013, read back 0x1000_0010. Write LEN=6, read 6. Every ack arrives exactly 1 cycle after stb; reading CTRL gives busy=0.
- Copy with BURST=4: SRC=0x0000_0100, DST=0x1000_0200, LEN=6, ie=1.
  - Bus sees 4 reads, 4 writes, 2 reads, 2 writes, with addresses incrementing by 4.
  - Destination matches source.
  - Ends with done=1, irq_o=1, LEN reads 0.
  - Writing 0x4 to CTRL afterwards clears irq_o.
- Zero length: start with LEN=0 gives done=1 within 2 cycles, with m_cyc_o never asserted.
- Error: slave asserts m_err_i on the 3rd read of LEN=8.
  - err=1, done=1, busy=0, m_cyc_o low the next cycle.
  - No write cycles occur; LEN reads 8.
- Wait states: slave model inserts 0-3 random wait cycles per word.
  - m_adr_o, m_dat_o and m_stb_o stay stable until ack.
  - A 37-word copy is data-correct.
- Reset mid-transfer: rst_i high for 1 cycle during WR.
  - Next cycle all outputs are 0 and CTRL reads 0.
  - A fresh start then completes normally.
